dmem_req_ctrl: RTL and testbench

DMEM_REQ_CTRL -- requirements
Module: dmem_req_ctrl

---
 rtl/dmem_req_ctrl.sv | 168 ++++++++++++++++
 tb/tb_dmem_req_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_req_ctrl.sv
// Data-memory request controller: turns the MEM-stage request into one SRAM-like
// bus transaction at a time and holds the load result while the pipeline is stalled.
module dmem_req_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m_data_req,
    input  logic        m_data_wr,
    input  logic [1:0]  m_data_size,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic        flush,
    input  logic        pipe_advance,
    output logic [31:0] m_data_rdata,
    output logic        mem_stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [1:0]  dbg_state
);

    // Bus handshake: data_req is the request valid and data_addr_ok its ready; the
    // request is accepted on the rising edge where both are high, and once raised
    // data_req and the bus fields stay unchanged until that edge. data_data_ok is a
    // single-cycle response strobe for the one accepted request, never for a new one.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        discard;
    logic        discard_nxt;
    logic [31:0] rdata_buf;
    logic        buf_wr;
    logic [1:0]  buf_size;
    logic [31:0] buf_addr;
    logic [31:0] buf_wdata;

    logic        issue;
    logic        resp_live;
    logic        leave_mem;

    always_comb begin
        issue     = m_data_req & ~flush;
        resp_live = (state == S_WAIT) & data_data_ok & ~discard;
        leave_mem = pipe_advance | flush;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The request buffer tracks the inputs while idle so REQ can replay them unchanged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            discard   <= 1'b0;
            rdata_buf <= '0;
            buf_wr    <= 1'b0;
            buf_size  <= '0;
            buf_addr  <= '0;
            buf_wdata <= '0;
        end else begin
            discard <= discard_nxt;
            if (state == S_IDLE) begin
                buf_wr    <= m_data_wr;
                buf_size  <= m_data_size;
                buf_addr  <= m_data_addr;
                buf_wdata <= m_data_wdata;
            end
            if (resp_live) begin
                rdata_buf <= data_rdata;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        discard_nxt = discard;
        case (state)
            S_IDLE: begin
                if (issue) begin
                    state_nxt = data_addr_ok ? S_WAIT : S_REQ;
                end
            end
            S_REQ: begin
                // A request already on the bus cannot be withdrawn; only its result is dropped.
                if (flush) begin
                    discard_nxt = 1'b1;
                end
                if (data_addr_ok) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    discard_nxt = 1'b0;
                    state_nxt   = (discard || leave_mem) ? S_IDLE : S_DONE;
                end else if (flush) begin
                    discard_nxt = 1'b1;
                end
            end
            S_DONE: begin
                if (leave_mem) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        data_req     = 1'b0;
        data_wr      = buf_wr;
        data_size    = buf_size;
        data_addr    = buf_addr;
        data_wdata   = buf_wdata;
        m_data_rdata = rdata_buf;
        mem_stall    = 1'b0;
        case (state)
            S_IDLE: begin
                data_req   = issue;
                data_wr    = m_data_wr;
                data_size  = m_data_size;
                data_addr  = m_data_addr;
                data_wdata = m_data_wdata;
                mem_stall  = m_data_req;
            end
            S_REQ: begin
                data_req  = 1'b1;
                mem_stall = 1'b1;
            end
            S_WAIT: begin
                mem_stall = ~resp_live;
                if (resp_live) begin
                    m_data_rdata = data_rdata;
                end
            end
            default: begin
                mem_stall = 1'b0;
            end
        endcase
        if (flush) begin
            mem_stall = 1'b0;
        end
        // Reset silences the bus and the pipeline immediately, not at the next edge.
        if (!resetn) begin
            data_req  = 1'b0;
            mem_stall = 1'b0;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Bench for dmem_req_ctrl: directed scenarios followed by a randomized core/memory
// run, all checked against a transaction-level model of the request rules.
module tb_dmem_req_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m_data_req = 1'b0;
  logic        m_data_wr = 1'b0;
  logic [1:0]  m_data_size = 2'd0;
  logic [31:0] m_data_addr = '0;
  logic [31:0] m_data_wdata = '0;
  logic        flush = 1'b0;
  logic        pipe_advance = 1'b0;
  logic [31:0] m_data_rdata;
  logic        mem_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok = 1'b0;
  logic        data_data_ok = 1'b0;
  logic [31:0] data_rdata = '0;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  // Pending response words for accepted transactions, in acceptance order.
  logic [31:0] exp_q[$];

  // Model: what is on the bus / in flight, and whether its owner is still alive.
  bit          m_out, m_live, m_held, m_held_live, m_done;
  logic [31:0] m_last;
  logic        h_wr;
  logic [1:0]  h_size;
  logic [31:0] h_addr, h_wdata;
  bit          e_req, e_stall, e_own;
  logic [31:0] e_rdata;

  always #5 clk = ~clk;

  dmem_req_ctrl dut (
    .clk(clk), .resetn(resetn),
    .m_data_req(m_data_req), .m_data_wr(m_data_wr), .m_data_size(m_data_size),
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
    .flush(flush), .pipe_advance(pipe_advance),
    .m_data_rdata(m_data_rdata), .mem_stall(mem_stall),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_out = 0; m_live = 0; m_held = 0; m_held_live = 0; m_done = 0; m_last = '0;
  endtask

  task automatic predict();
    if (!resetn) begin
      model_clear();
      e_req = 0; e_stall = 0; e_own = 0; e_rdata = '0;
      return;
    end
    e_own   = m_out && data_data_ok && m_live;
    e_req   = m_held || (m_data_req && !flush && !m_out && !m_done);
    e_stall = !flush && ((m_data_req && !m_done && !e_own) || m_held || (m_out && !e_own));
    e_rdata = e_own ? data_rdata : m_last;
  endtask

  task automatic settle();
    #1;
    predict();
    check("data_req", {31'd0, data_req}, {31'd0, e_req});
    check("mem_stall", {31'd0, mem_stall}, {31'd0, e_stall});
    check("m_data_rdata", m_data_rdata, e_rdata);
    if (e_req) begin
      check("data_wr", {31'd0, data_wr}, {31'd0, m_held ? h_wr : m_data_wr});
      check("data_size", {30'd0, data_size}, {30'd0, m_held ? h_size : m_data_size});
      check("data_addr", data_addr, m_held ? h_addr : m_data_addr);
      check("data_wdata", data_wdata, m_held ? h_wdata : m_data_wdata);
    end
  endtask

  task automatic tick();
    bit out0, acc, rsp, leave;
    @(posedge clk);
    if (!resetn) begin
      model_clear();
      exp_q.delete();
    end else begin
      out0  = m_out;
      acc   = e_req && data_addr_ok;
      rsp   = m_out && data_data_ok;
      leave = pipe_advance || flush;
      if (rsp) begin
        m_out = 0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (leave) m_done = 0;
      if (e_own) begin
        m_last = data_rdata;
        if (!leave) m_done = 1;
      end
      if (acc) begin
        m_live = m_held ? (m_held_live && !flush) : 1'b1;
        m_out  = 1;
        m_held = 0;
        exp_q.push_back($urandom);
      end else if (e_req && !m_held) begin
        m_held = 1; m_held_live = 1;
        h_wr = m_data_wr; h_size = m_data_size; h_addr = m_data_addr; h_wdata = m_data_wdata;
      end else if (m_held && flush) begin
        m_held_live = 0;
      end
      if (out0 && !rsp && flush) m_live = 0;
    end
    @(negedge clk);
  endtask

  task automatic set_in(input logic req, input logic wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic fl, input logic adv, input logic aok,
                        input logic dok, input logic [31:0] rd);
    m_data_req = req; m_data_wr = wr; m_data_size = size;
    m_data_addr = addr; m_data_wdata = wdata;
    flush = fl; pipe_advance = adv; data_addr_ok = aok; data_data_ok = dok; data_rdata = rd;
  endtask

  initial begin
    bit take_new;
    model_clear();

    // Reset state
    @(negedge clk);
    set_in(1, 0, 2, 32'h100, 0, 0, 0, 1, 0, 0);
    settle();
    check("rst_data_req", {31'd0, data_req}, 32'd0);
    check("rst_mem_stall", {31'd0, mem_stall}, 32'd0);
    check("rst_rdata", m_data_rdata, 32'd0);
    check("rst_state_idle", {30'd0, dbg_state}, 32'd0);
    tick();
    resetn = 1'b1;

    // Back-to-back load handshake
    set_in(1, 0, 2, 32'h100, 0, 0, 0, 1, 0, 0);
    settle();
    check("t028_req", {31'd0, data_req}, 32'd1);
    check("t028_stall", {31'd0, mem_stall}, 32'd1);
    tick();
    set_in(1, 0, 2, 32'h100, 0, 0, 1, 0, 1, 32'h12345678);
    settle();
    check("t028_rdata", m_data_rdata, 32'h12345678);
    check("t028_stall_done", {31'd0, mem_stall}, 32'd0);
    check("t028_noreq", {31'd0, data_req}, 32'd0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0bad0bad);
    settle();
    check("t028_idle_rdata", m_data_rdata, 32'h12345678);
    tick();

    // Store held on the bus while addr_ok is delayed and inputs move
    set_in(1, 1, 2, 32'h80000010, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        m_data_addr  = 32'h00001000 + 32'(k);
        m_data_wdata = $urandom;
        data_addr_ok = (k == 3);
      end
      settle();
      check("t029_addr", data_addr, 32'h80000010);
      check("t029_wdata", data_wdata, 32'hDEADBEEF);
      check("t029_stall", {31'd0, mem_stall}, 32'd1);
      tick();
    end
    set_in(1, 1, 2, 32'h80000010, 32'hDEADBEEF, 0, 1, 0, 1, 32'h00000055);
    settle();
    check("t029_stall_end", {31'd0, mem_stall}, 32'd0);
    tick();

    // Load result held while the pipeline stays stalled
    set_in(1, 0, 2, 32'h300, 0, 0, 0, 1, 0, 0);
    settle();
    tick();
    set_in(1, 0, 2, 32'h300, 0, 0, 0, 1, 1, 32'hCAFEF00D);
    settle();
    check("t030_bypass", m_data_rdata, 32'hCAFEF00D);
    tick();
    for (int k = 0; k < 5; k++) begin
      set_in(1, 0, 2, 32'h300, 0, 0, (k == 4), 1, 0, $urandom);
      settle();
      check("t030_hold_rdata", m_data_rdata, 32'hCAFEF00D);
      check("t030_hold_stall", {31'd0, mem_stall}, 32'd0);
      check("t030_no_reissue", {31'd0, data_req}, 32'd0);
      tick();
    end

    // Flush in WAIT; the next load waits for the discarded response
    set_in(1, 0, 2, 32'h400, 0, 0, 0, 1, 0, 0);
    settle();
    tick();
    set_in(1, 0, 2, 32'h400, 0, 1, 0, 1, 0, 0);
    settle();
    tick();
    set_in(1, 0, 2, 32'h500, 0, 0, 0, 1, 0, 0);
    settle();
    check("t031_withheld", {31'd0, data_req}, 32'd0);
    check("t031_stall", {31'd0, mem_stall}, 32'd1);
    tick();
    set_in(1, 0, 2, 32'h500, 0, 0, 0, 1, 1, 32'h11111111);
    settle();
    check("t031_withheld_ok", {31'd0, data_req}, 32'd0);
    check("t031_no_old_data", m_data_rdata, 32'hCAFEF00D);
    check("t031_stall_ok", {31'd0, mem_stall}, 32'd1);
    tick();
    set_in(1, 0, 2, 32'h500, 0, 0, 0, 1, 0, 0);
    settle();
    check("t031_new_req", {31'd0, data_req}, 32'd1);
    check("t031_new_addr", data_addr, 32'h500);
    tick();
    set_in(1, 0, 2, 32'h500, 0, 0, 1, 0, 1, 32'h22222222);
    settle();
    check("t031_new_data", m_data_rdata, 32'h22222222);
    tick();

    // Reset in WAIT abandons the transaction
    set_in(1, 0, 2, 32'h600, 0, 0, 0, 1, 0, 0);
    settle();
    tick();
    resetn = 1'b0;
    settle();
    check("t032_req", {31'd0, data_req}, 32'd0);
    check("t032_stall", {31'd0, mem_stall}, 32'd0);
    check("t032_rdata", m_data_rdata, 32'd0);
    tick();
    resetn = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h33333333);
    settle();
    check("t032_stale", m_data_rdata, 32'd0);
    tick();
    set_in(1, 0, 2, 32'h200, 0, 0, 0, 0, 0, 0);
    settle();
    check("t032_next_req", {31'd0, data_req}, 32'd1);
    tick();
    set_in(1, 0, 2, 32'h200, 0, 0, 0, 1, 0, 0);
    settle();
    tick();
    set_in(1, 0, 2, 32'h200, 0, 0, 1, 0, 1, 32'h44444444);
    settle();
    check("t032_next_data", m_data_rdata, 32'h44444444);
    tick();

    // Randomized core and memory
    take_new = 1;
    for (int i = 0; i < 3000; i++) begin
      resetn = ($urandom_range(0, 199) != 0);
      if (take_new) begin
        m_data_req   = ($urandom_range(0, 9) < 6);
        m_data_wr    = $urandom_range(0, 1);
        m_data_size  = 2'($urandom_range(0, 2));
        m_data_addr  = $urandom;
        m_data_wdata = $urandom;
      end
      flush        = ($urandom_range(0, 15) == 0);
      data_addr_ok = $urandom_range(0, 1);
      data_data_ok = m_out && (exp_q.size() > 0) && ($urandom_range(0, 2) == 0);
      data_rdata   = data_data_ok ? exp_q[0] : $urandom;
      predict();
      pipe_advance = !flush && !e_stall && ($urandom_range(0, 3) != 0);
      settle();
      tick();
      take_new = pipe_advance || flush || !resetn;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
